comp_ora: RTL and testbench
===========================

Name: comp_ora

Overview:
- Multi-channel comparator output response analyser (ORA) for the LBIST controller.
- Each cycle, compares CHANNELS response-compactor words (rc_op) against fault-free golden signatures (ff_sig).
- Adds session control, sticky per-channel fail flags, a saturating mismatch counter, first-fail pattern capture and a pass/done verdict.
- Sits between the response compactors and the BIST controller/status register.

Parameters:
- RC_BITS, 2: width of one channel's compared word.
- CHANNELS, 4: number of independent compared channels.
- CNT_BITS, 8: width of fail_cnt (saturating).
- IDX_BITS, 16: width of the pattern index counter and of first_fail_idx.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  begin a new session; clears all results.
- cmp_en  input  1  rc_op/ff_sig valid this cycle; compare them.
- last  input  1  qualifies the final compare of the session (ignored unless cmp_en=1).
- rc_op  input  CHANNELS*RC_BITS  compactor outputs; channel k occupies bits [k*RC_BITS +: RC_BITS].
- ff_sig  input  CHANNELS*RC_BITS  golden signatures, same packing as rc_op.
- res  output  1  registered per-compare mismatch (any channel), 1-cycle latency.
- ch_fail  output  CHANNELS  sticky per-channel mismatch flags.
- fail_cnt  output  CNT_BITS  number of compares with at least one mismatching channel; saturating.
- first_fail_idx  output  IDX_BITS  pattern index of the first mismatching compare.
- first_fail_vld  output  1  first_fail_idx is valid.
- done  output  1  session complete.
- pass  output  1  done and no channel failed.

Behaviour:
- Reset (rst_n=0, asynchronous): state=IDLE; every output and internal register = 0, including idx and pass.
- States: IDLE, RUN, DONE.
- IDLE -> RUN on start=1.
- RUN -> DONE on cmp_en=1 and last=1, after that final compare is recorded.
- DONE -> RUN on start=1.
- start=1 in RUN restarts the session.
- Session clear on start (any state), effective at the edge where start=1:
  - ch_fail=0, fail_cnt=0, first_fail_vld=0, first_fail_idx=0, idx=0, done=0, pass=0, res=0.
  - A cmp_en in the same cycle is dropped; start has priority.
- Compare, RUN state with cmp_en=1:
  - mism[k] = (rc_op chan k != ff_sig chan k).
  - res <= |mism.
  - ch_fail <= ch_fail | mism.
  - If |mism: fail_cnt <= fail_cnt+1, holding at 2^CNT_BITS-1 (no wrap).
  - If |mism and first_fail_vld=0: first_fail_idx <= idx, first_fail_vld <= 1.
  - idx <= idx+1, saturating at 2^IDX_BITS-1.
  - After saturation, first_fail_idx captures the saturated value.
- RUN with cmp_en=0: res <= 0; all other results hold.
- IDLE and DONE: cmp_en and last are ignored; res <= 0; results hold.
- Entering DONE: done <= 1 and pass <= ~|(ch_fail | mism) in the same edge as the final compare. Both hold until start or reset.
- last=1 with cmp_en=0: no effect.
- Reset asserted mid-session: immediate clear to reset values. A session is only resumed by a new start.
- Observation: all outputs are registered; no combinational path from inputs to outputs.

Optional Feature:
- Macro: COMP_ORA_MASK_EN.
- When defined:
  - Adds input cmp_mask, width CHANNELS*RC_BITS, same packing as rc_op.
  - A bit with mask=1 is excluded from comparison (X-masking).
  - mism[k] = |((rc_op_k ^ ff_sig_k) & ~mask_k).
  - A fully masked channel never fails.
- When undefined: the port does not exist and all bits are compared.

Test Plan:
- Reset then idle: rst_n=0 mid-run, then release -> all outputs 0, state IDLE; cmp_en=1 with mismatching data before start -> res stays 0, fail_cnt=0.
- Clean session: start, then 10 compares with rc_op==ff_sig, last on the 10th -> res=0 throughout; done=1 and pass=1 one cycle after the 10th compare; fail_cnt=0; first_fail_vld=0.
- Failing session (CHANNELS=4, RC_BITS=2):
  - Compares at idx 0..7; channel 2 mismatches at idx 3 and idx 6, channel 0 at idx 6.
  - Required: res=1 the cycle after idx 3 and after idx 6.
  - Final: ch_fail=4'b0101, fail_cnt=2, first_fail_idx=3, pass=0, done=1.
- Saturation (CNT_BITS=2): 6 consecutive mismatching compares -> fail_cnt sequence 1,2,3,3,3,3.
- Priority and restart:
  - start=1 and cmp_en=1 with a mismatch in the same cycle -> mismatch dropped, fail_cnt=0.
  - start asserted in DONE after a failed session -> all results clear, done=0, next compare recorded at idx 0.
- Mask (COMP_ORA_MASK_EN defined): ff_sig bit 1 of channel 1 differs, cmp_mask bit 1 of channel 1 = 1 -> res=0, pass=1; same stimulus with mask=0 -> ch_fail[1]=1, pass=0.

Source files
------------

// File: rtl/comp_ora.sv
// rtl/comp_ora.sv - multi-channel comparator ORA with session control and verdict
// Optional X-masking input cmp_mask enabled by defining COMP_ORA_MASK_EN.
module comp_ora #(
  parameter int RC_BITS  = 2,
  parameter int CHANNELS = 4,
  parameter int CNT_BITS = 8,
  parameter int IDX_BITS = 16
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         start,
  input  logic                         cmp_en,
  input  logic                         last,
  input  logic [CHANNELS*RC_BITS-1:0]  rc_op,
  input  logic [CHANNELS*RC_BITS-1:0]  ff_sig,
`ifdef COMP_ORA_MASK_EN
  input  logic [CHANNELS*RC_BITS-1:0]  cmp_mask,
`endif
  output logic                         res,
  output logic [CHANNELS-1:0]          ch_fail,
  output logic [CNT_BITS-1:0]          fail_cnt,
  output logic [IDX_BITS-1:0]          first_fail_idx,
  output logic                         first_fail_vld,
  output logic                         done,
  output logic                         pass
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic [CNT_BITS-1:0] CNT_MAX = '1;
  localparam logic [IDX_BITS-1:0] IDX_MAX = '1;

  logic [1:0]                   state;
  logic [IDX_BITS-1:0]          idx;
  logic [CHANNELS*RC_BITS-1:0]  diff;
  logic [CHANNELS-1:0]          mism;
  logic                         any_mism;

`ifdef COMP_ORA_MASK_EN
  assign diff = (rc_op ^ ff_sig) & ~cmp_mask;
`else
  assign diff = rc_op ^ ff_sig;
`endif

  always_comb begin
    mism = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      mism[k] = |diff[k*RC_BITS +: RC_BITS];
    end
  end

  assign any_mism = |mism;

  // start wins over everything, including a compare presented in the same cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= ST_IDLE;
      idx            <= '0;
      res            <= 1'b0;
      ch_fail        <= '0;
      fail_cnt       <= '0;
      first_fail_idx <= '0;
      first_fail_vld <= 1'b0;
      done           <= 1'b0;
      pass           <= 1'b0;
    end else if (start) begin
      state          <= ST_RUN;
      idx            <= '0;
      res            <= 1'b0;
      ch_fail        <= '0;
      fail_cnt       <= '0;
      first_fail_idx <= '0;
      first_fail_vld <= 1'b0;
      done           <= 1'b0;
      pass           <= 1'b0;
    end else if (state == ST_RUN && cmp_en) begin
      res     <= any_mism;
      ch_fail <= ch_fail | mism;
      if (any_mism && fail_cnt != CNT_MAX) begin
        fail_cnt <= fail_cnt + 1'b1;
      end
      if (any_mism && !first_fail_vld) begin
        first_fail_idx <= idx;
        first_fail_vld <= 1'b1;
      end
      if (idx != IDX_MAX) begin
        idx <= idx + 1'b1;
      end
      if (last) begin
        state <= ST_DONE;
        done  <= 1'b1;
        pass  <= ~|(ch_fail | mism);
      end
    end else begin
      res <= 1'b0;
    end
  end

endmodule

// File: tb/tb_comp_ora.sv
// tb/tb_comp_ora.sv - directed self-checking bench for comp_ora
// Mask cases are exercised only when COMP_ORA_MASK_EN is defined.
module tb_comp_ora;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start, cmp_en, last;
  logic [7:0] rc_op, ff_sig;
  logic [7:0] cmp_mask;

  logic       res, first_fail_vld, done, pass;
  logic [3:0] ch_fail;
  logic [7:0] fail_cnt;
  logic [15:0] first_fail_idx;

  logic       s_res, s_ffv, s_done, s_pass;
  logic [3:0] s_ch_fail;
  logic [1:0] s_fail_cnt;
  logic [1:0] s_ffi;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  comp_ora u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .cmp_en(cmp_en), .last(last),
    .rc_op(rc_op), .ff_sig(ff_sig),
`ifdef COMP_ORA_MASK_EN
    .cmp_mask(cmp_mask),
`endif
    .res(res), .ch_fail(ch_fail), .fail_cnt(fail_cnt),
    .first_fail_idx(first_fail_idx), .first_fail_vld(first_fail_vld),
    .done(done), .pass(pass)
  );

  comp_ora #(.CNT_BITS(2), .IDX_BITS(2)) u_sat (
    .clk(clk), .rst_n(rst_n), .start(start), .cmp_en(cmp_en), .last(last),
    .rc_op(rc_op), .ff_sig(ff_sig),
`ifdef COMP_ORA_MASK_EN
    .cmp_mask(cmp_mask),
`endif
    .res(s_res), .ch_fail(s_ch_fail), .fail_cnt(s_fail_cnt),
    .first_fail_idx(s_ffi), .first_fail_vld(s_ffv),
    .done(s_done), .pass(s_pass)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic s, input logic e, input logic l,
                      input logic [7:0] rc, input logic [7:0] ff);
    start  = s;
    cmp_en = e;
    last   = l;
    rc_op  = rc;
    ff_sig = ff;
    @(posedge clk);
    #1;
  endtask

  task automatic check_clear(input string tag);
    check({tag, "_res"},  32'(res), 0);
    check({tag, "_chf"},  32'(ch_fail), 0);
    check({tag, "_cnt"},  32'(fail_cnt), 0);
    check({tag, "_ffi"},  32'(first_fail_idx), 0);
    check({tag, "_ffv"},  32'(first_fail_vld), 0);
    check({tag, "_done"}, 32'(done), 0);
    check({tag, "_pass"}, 32'(pass), 0);
  endtask

  initial begin
    rst_n = 1'b0;
    start = 0; cmp_en = 0; last = 0; rc_op = 0; ff_sig = 0; cmp_mask = 0;
    repeat (2) @(posedge clk);
    #1;
    check_clear("por");
    rst_n = 1'b1;

    // asynchronous reset mid-session
    step(1, 0, 0, 8'h00, 8'h00);
    step(0, 1, 0, 8'h01, 8'h00);
    check("pre_rst_res", 32'(res), 1);
    check("pre_rst_cnt", 32'(fail_cnt), 1);
    #2 rst_n = 1'b0;
    #1;
    check_clear("async_rst");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    step(0, 1, 1, 8'hFF, 8'h00);
    check("idle_res", 32'(res), 0);
    check("idle_cnt", 32'(fail_cnt), 0);
    check("idle_done", 32'(done), 0);

    // clean session of 10 compares
    step(1, 0, 0, 8'h00, 8'h00);
    for (int i = 0; i < 10; i++) begin
      step(0, 1, (i == 9), 8'(i * 7), 8'(i * 7));
      check($sformatf("clean_res%0d", i), 32'(res), 0);
      if (i == 8) check("clean_done_early", 32'(done), 0);
    end
    check("clean_done", 32'(done), 1);
    check("clean_pass", 32'(pass), 1);
    check("clean_cnt", 32'(fail_cnt), 0);
    check("clean_ffv", 32'(first_fail_vld), 0);

    // failing session: ch2 at idx 3 and 6, ch0 at idx 6
    step(1, 0, 0, 8'h00, 8'h00);
    for (int i = 0; i < 8; i++) begin
      logic [7:0] rc;
      rc = (i == 3) ? 8'h10 : (i == 6) ? 8'h11 : 8'h00;
      step(0, 1, (i == 7), rc, 8'h00);
      check($sformatf("fail_res%0d", i), 32'(res), ((i == 3) || (i == 6)) ? 1 : 0);
    end
    check("fail_chf", 32'(ch_fail), 4'b0101);
    check("fail_cnt", 32'(fail_cnt), 2);
    check("fail_ffi", 32'(first_fail_idx), 3);
    check("fail_ffv", 32'(first_fail_vld), 1);
    check("fail_pass", 32'(pass), 0);
    check("fail_done", 32'(done), 1);

    // compares after DONE are ignored
    step(0, 1, 0, 8'hFF, 8'h00);
    check("done_ign_res", 32'(res), 0);
    check("done_ign_cnt", 32'(fail_cnt), 2);

    // start with a simultaneous mismatching compare: compare is dropped
    step(1, 1, 0, 8'hFF, 8'h00);
    check_clear("restart");
    step(0, 1, 0, 8'h40, 8'h00);
    check("restart_res", 32'(res), 1);
    check("restart_ffi", 32'(first_fail_idx), 0);
    check("restart_ffv", 32'(first_fail_vld), 1);
    check("restart_cnt", 32'(fail_cnt), 1);
    check("restart_chf", 32'(ch_fail), 4'b1000);

    // last without cmp_en has no effect, cmp_en=0 clears res
    step(0, 0, 1, 8'hFF, 8'h00);
    check("last_only_done", 32'(done), 0);
    check("last_only_res", 32'(res), 0);
    check("last_only_cnt", 32'(fail_cnt), 1);

    // fail counter saturation on the narrow instance
    step(1, 0, 0, 8'h00, 8'h00);
    for (int i = 0; i < 6; i++) begin
      step(0, 1, 0, 8'h02, 8'h00);
      check($sformatf("sat_cnt%0d", i), 32'(s_fail_cnt), (i < 3) ? i + 1 : 3);
      check($sformatf("wide_cnt%0d", i), 32'(fail_cnt), i + 1);
    end

    // pattern index saturation: first mismatch at compare 5 captures idx 3 on the narrow instance
    step(1, 0, 0, 8'h00, 8'h00);
    for (int i = 0; i < 4; i++) step(0, 1, 0, 8'h00, 8'h00);
    step(0, 1, 1, 8'h80, 8'h00);
    check("idxsat_ffi", 32'(s_ffi), 3);
    check("idxwide_ffi", 32'(first_fail_idx), 4);
    check("idxsat_done", 32'(s_done), 1);
    check("idxsat_pass", 32'(s_pass), 0);

`ifdef COMP_ORA_MASK_EN
    // channel 1 bit 1 differs but is masked out
    cmp_mask = 8'h08;
    step(1, 0, 0, 8'h00, 8'h00);
    step(0, 1, 1, 8'h00, 8'h08);
    check("mask_res", 32'(res), 0);
    check("mask_pass", 32'(pass), 1);
    check("mask_chf", 32'(ch_fail), 0);
    cmp_mask = 8'h00;
    step(1, 0, 0, 8'h00, 8'h00);
    step(0, 1, 1, 8'h00, 8'h08);
    check("nomask_res", 32'(res), 1);
    check("nomask_chf1", 32'(ch_fail[1]), 1);
    check("nomask_pass", 32'(pass), 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
